// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the parametrised lane demux
// Purpose: routing mode encodings and stall counter sizing.
// Ports:   none (package).
package demux_pkg;

   localparam logic MODE_RR  = 1'b0;   // round-robin across lanes
   localparam logic MODE_SEL = 1'b1;   // lane chosen by selector

   localparam int            STALL_W   = 16;
   localparam logic [15:0]   STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - first-word fall-through FIFO for one output lane
// Purpose: buffers words for one lane; head word is presented combinationally.
// Ports:   clk, reset (async active-low), flush (sync clear),
//          push/din write side, pop/dout read side, empty/full status.
module lane_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   assign empty = (count == '0);
   assign full  = (count == (PTR_W+1)'(DEPTH));

   // Flush wins over any transfer; guards keep a misbehaving caller from
   // corrupting the count.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // Empty lanes present zero rather than stale storage.
   assign dout = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   // Storage needs no reset: contents are only observable through count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/demux_lanes_param.sv
// rtl/demux_lanes_param.sv - 1-to-NUM_LANES word demux with per-lane FIFOs
// Purpose: routes the input stream round-robin or by selector into lane FIFOs.
// Ports:   clk, reset (async active-low), flush, mode, selector,
//          Entrada/validEntrada/readyEntrada input stream,
//          SalidaF/validSalida/readySalida packed lane outputs,
//          rr_ptr next round-robin lane, stall_cnt saturating stall count.
module demux_lanes_param
   import demux_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_LANES = 4,
   parameter int DEPTH     = 4,
   parameter int LANE_W    = $clog2(NUM_LANES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        mode,
   input  logic [LANE_W-1:0]           selector,
   input  logic [DATA_W-1:0]           Entrada,
   input  logic                        validEntrada,
   output logic                        readyEntrada,
   output logic [NUM_LANES*DATA_W-1:0] SalidaF,
   output logic [NUM_LANES-1:0]        validSalida,
   input  logic [NUM_LANES-1:0]        readySalida,
   output logic [LANE_W-1:0]           rr_ptr,
   output logic [STALL_W-1:0]          stall_cnt
);

   logic [LANE_W-1:0]    target;
   logic                 target_ok;
   logic                 target_full;
   logic                 accept;
   logic [NUM_LANES-1:0] full_vec;
   logic [NUM_LANES-1:0] empty_vec;
   logic [NUM_LANES-1:0] push_vec;
   logic [NUM_LANES-1:0] pop_vec;

   assign target = (mode == MODE_SEL) ? selector : rr_ptr;

   // Out-of-range selectors are possible when NUM_LANES is not a power of two.
   assign target_ok = (mode == MODE_RR) ||
                      ({1'b0, selector} < (LANE_W+1)'(NUM_LANES));

   // Decode by comparison so an out-of-range target never indexes past full_vec.
   always_comb begin
      target_full = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (target == LANE_W'(i)) target_full = full_vec[i];
      end
   end

   // No bypass: a full lane refuses input even if it is popped this cycle.
   assign readyEntrada = target_ok & ~target_full & ~flush;
   assign accept       = validEntrada & readyEntrada;

   always_comb begin
      push_vec = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         push_vec[i] = accept && (target == LANE_W'(i));
      end
   end

   assign validSalida = ~empty_vec;
   assign pop_vec     = readySalida & ~empty_vec & {NUM_LANES{~flush}};

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push_vec[g]),
            .din   (Entrada),
            .pop   (pop_vec[g]),
            .dout  (SalidaF[g*DATA_W +: DATA_W]),
            .empty (empty_vec[g]),
            .full  (full_vec[g])
         );
      end
   endgenerate

   // rr_ptr moves only on round-robin accepts so directed traffic does not
   // disturb the rotation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (flush) begin
         rr_ptr <= '0;
      end else if (accept && (mode == MODE_RR)) begin
         rr_ptr <= (rr_ptr == LANE_W'(NUM_LANES-1)) ? '0 : rr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (flush) begin
         stall_cnt <= '0;
      end else if (validEntrada && !readyEntrada && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_lanes_param.sv
// tb/tb_demux_lanes_param.sv - randomized self-checking bench for demux_lanes_param
module tb_demux_lanes_param;

   localparam int DATA_W = 8;
   localparam int NL     = 4;
   localparam int DEPTH  = 4;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          mode;
   logic [1:0]    selector;
   logic [7:0]    Entrada;
   logic          validEntrada;
   logic          readyEntrada;
   logic [31:0]   SalidaF;
   logic [3:0]    validSalida;
   logic [3:0]    readySalida;
   logic [1:0]    rr_ptr;
   logic [15:0]   stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one queue per lane plus the round-robin index and stall count.
   logic [7:0] mq [NL][$];
   int         m_rr;
   int         m_stall;

   demux_lanes_param #(.DATA_W(DATA_W), .NUM_LANES(NL), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .mode         (mode),
      .selector     (selector),
      .Entrada      (Entrada),
      .validEntrada (validEntrada),
      .readyEntrada (readyEntrada),
      .SalidaF      (SalidaF),
      .validSalida  (validSalida),
      .readySalida  (readySalida),
      .rr_ptr       (rr_ptr),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NL; i++) mq[i].delete();
      m_rr    = 0;
      m_stall = 0;
   endtask

   function automatic int model_target();
      return (mode == 1'b1) ? int'(selector) : m_rr;
   endfunction

   function automatic logic model_ready();
      int t;
      t = model_target();
      if (flush) return 1'b0;
      if (t >= NL) return 1'b0;
      return (mq[t].size() < DEPTH);
   endfunction

   task automatic compare_all(input string tag);
      logic [31:0] exp_dout;
      logic [3:0]  exp_valid;
      exp_dout  = '0;
      exp_valid = '0;
      for (int i = 0; i < NL; i++) begin
         if (mq[i].size() > 0) begin
            exp_valid[i]          = 1'b1;
            exp_dout[i*8 +: 8]    = mq[i][0];
         end
      end
      check({tag, ".ready"}, {31'd0, readyEntrada}, {31'd0, model_ready()});
      check({tag, ".valid"}, {28'd0, validSalida}, {28'd0, exp_valid});
      check({tag, ".dout"},  SalidaF, exp_dout);
      check({tag, ".rr"},    {30'd0, rr_ptr}, 32'(m_rr));
      check({tag, ".stall"}, {16'd0, stall_cnt}, 32'(m_stall));
   endtask

   // Apply the model's view of one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic rdy;
      int   t;
      rdy = model_ready();
      t   = model_target();
      if (flush) begin
         model_clear();
      end else begin
         if (validEntrada && !rdy && m_stall < 65535) m_stall++;
         for (int i = 0; i < NL; i++) begin
            if (readySalida[i] && mq[i].size() > 0) void'(mq[i].pop_front());
         end
         if (validEntrada && rdy) begin
            mq[t].push_back(Entrada);
            if (mode == 1'b0) m_rr = (m_rr + 1) % NL;
         end
      end
   endtask

   // Drive at the falling edge, check just after, then take the rising edge.
   task automatic step(input string tag, input logic fl, input logic m, input logic [1:0] sel,
                       input logic [7:0] d, input logic v, input logic [3:0] rs);
      flush        = fl;
      mode         = m;
      selector     = sel;
      Entrada      = d;
      validEntrada = v;
      readySalida  = rs;
      #1;
      compare_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      flush = 0; mode = 0; selector = 0; Entrada = 0; validEntrada = 0; readySalida = 0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check("reset.valid", {28'd0, validSalida}, 32'd0);
      check("reset.dout",  SalidaF, 32'd0);
      check("reset.ready", {31'd0, readyEntrada}, 32'd1);
      reset = 1'b1;

      // Round-robin distribution with consumers always ready.
      for (int k = 0; k < 8; k++) step("rr", 0, 0, 0, 8'(8'h10 + k), 1, 4'hF);
      step("rr_drain", 0, 0, 0, 0, 0, 4'hF);
      check("rr_wrap", {30'd0, rr_ptr}, 32'd0);

      // Fill every lane with consumers stalled; the 17th word is refused.
      step("pre_flush", 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 17; k++) step("fill", 0, 0, 0, 8'(8'h20 + k), 1, 4'h0);
      check("fill.valid", {28'd0, validSalida}, 32'hF);
      check("fill.stall", {16'd0, stall_cnt}, 32'd1);
      check("fill.lane0", {24'd0, SalidaF[7:0]}, 32'h20);
      check("fill.lane3", {24'd0, SalidaF[31:24]}, 32'h23);

      // Directed lane 2: three words, then simultaneous push and pop.
      step("fl2", 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step("sel2", 0, 1, 2, 8'(8'h30 + k), 1, 4'h0);
      step("pushpop", 0, 1, 2, 8'h33, 1, 4'b0100);
      check("pushpop.head", {24'd0, SalidaF[23:16]}, 32'h31);
      check("pushpop.valid", {28'd0, validSalida}, 32'h4);
      // Fill lane 2, then pop while offering: no bypass.
      step("sel2_fill", 0, 1, 2, 8'h34, 1, 4'h0);
      step("nobypass", 0, 1, 2, 8'h35, 1, 4'b0100);
      check("nobypass.ready", {31'd0, readyEntrada}, 32'd1);
      step("after_nb", 0, 1, 2, 8'h36, 0, 4'h0);

      // Mode switch: rr resumes from the held pointer.
      step("fl3", 1, 0, 0, 0, 0, 0);
      step("ms0", 0, 0, 0, 8'h40, 1, 0);
      step("ms1", 0, 0, 0, 8'h41, 1, 0);
      step("ms2", 0, 1, 0, 8'h42, 1, 0);
      step("ms3", 0, 0, 0, 8'h43, 1, 0);
      check("ms.lane2", {24'd0, SalidaF[23:16]}, 32'h43);
      check("ms.lane0", {24'd0, SalidaF[7:0]}, 32'h40);

      // Flush with partially filled lanes.
      step("pf", 0, 0, 0, 8'h44, 1, 0);
      step("flush", 1, 0, 0, 8'h45, 1, 0);
      check("flush.valid", {28'd0, validSalida}, 32'd0);
      step("post_flush", 0, 0, 0, 8'h46, 1, 0);
      check("post_flush.lane0", {24'd0, SalidaF[7:0]}, 32'h46);

      // Asynchronous reset mid-stream clears state without waiting for an edge.
      step("pre_rst", 0, 0, 0, 8'h47, 1, 0);
      #3;
      reset = 1'b0;
      #1;
      model_clear();
      check("arst.valid", {28'd0, validSalida}, 32'd0);
      check("arst.dout",  SalidaF, 32'd0);
      check("arst.rr",    {30'd0, rr_ptr}, 32'd0);
      check("arst.stall", {16'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step("post_rst", 0, 0, 0, 8'h48, 1, 0);
      check("post_rst.lane0", {24'd0, SalidaF[7:0]}, 32'h48);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 3000; k++) begin
         step("rand",
              ($urandom_range(0, 59) == 0),
              1'($urandom),
              2'($urandom),
              8'($urandom),
              ($urandom_range(0, 3) != 0),
              4'($urandom));
      end
      idle();
      #1;
      compare_all("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
